decimal_key_debouncer: RTL

//   Front-end for the 10-key decimal keypad. Synchronises the raw key lines,

---
 rtl/keypad_pkg.sv | 8 +
 rtl/bit_synchronizer.sv | 16 +
 rtl/decimal_key_debouncer.sv | 70 +++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the decimal keypad front-end
package keypad_pkg;
  localparam int KEY_W = 10;
  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} key_state_t;
  function automatic logic is_onehot(input logic [KEY_W-1:0] vec);
    return vec != '0 && (vec & (vec - KEY_W'(1))) == '0;
  endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: STAGES-deep flop chain bringing asynchronous lines into clk
module bit_synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] chain;
  always_ff @(posedge clk)
    if (rst) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/decimal_key_debouncer.sv
// decimal_key_debouncer: synchronise, debounce and single-key-filter the decimal keypad
module decimal_key_debouncer
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = KEY_W,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_onehot,
  output logic                key_valid,
  output logic                key_held,
  output logic                key_error
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [NUM_KEYS-1:0] sync, cand;
  logic [CW-1:0] cnt;
  key_state_t state;
  bit_synchronizer #(.WIDTH(NUM_KEYS), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .d(key_raw), .q(sync)
  );
  // The counter only ever reaches LAST; leaving the debounce state is what stops it.
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      key_onehot <= '0;
      key_valid  <= 1'b0;
      key_error  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_error <= 1'b0;
      case (state)
        IDLE:
          if (sync != '0) begin
            cand  <= sync;
            cnt   <= '0;
            state <= DEB_PRESS;
          end
        DEB_PRESS:
          if (sync != cand) state <= IDLE;
          else if (cnt == LAST) begin
            state <= PRESSED;
            if (is_onehot(cand)) begin
              key_onehot <= cand;
              key_valid  <= 1'b1;
              key_held   <= 1'b1;
            end else key_error <= 1'b1;
          end else cnt <= cnt + CW'(1);
        PRESSED:
          if (sync == '0) begin
            cnt   <= '0;
            state <= DEB_RELEASE;
          end
        DEB_RELEASE:
          if (sync != '0) state <= PRESSED;
          else if (cnt == LAST) begin
            state      <= IDLE;
            key_onehot <= '0;
            key_held   <= 1'b0;
          end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule
